// File: rtl/r2r_seq_pkg.sv
// Shared types and constants for the R2R ladder wave sequencer.
package r2r_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  localparam logic [1:0] CFG_DIV_LO = 2'd0;
  localparam logic [1:0] CFG_DIV_HI = 2'd1;
  localparam logic [1:0] CFG_STEP   = 2'd2;
  localparam logic [1:0] CFG_MODE   = 2'd3;

  localparam int unsigned DIV_RESET_DEFAULT = 32'd999;
  localparam logic [7:0]  STEP_RESET        = 8'h01;

endpackage

// File: rtl/r2r_sample_fifo.sv
// Small synchronous sample FIFO; pointers carry a wrap bit so full/empty
// fall straight out of the pointer difference.
module r2r_sample_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [7:0]   mem_r [DEPTH];
  logic         do_push_s;
  logic         do_pop_s;

  always_comb begin
    count     = wr_ptr_r - rd_ptr_r;
    full      = (count == (AW+1)'(DEPTH));
    empty     = (wr_ptr_r == rd_ptr_r);
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    rdata     = mem_r[rd_ptr_r[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // storage needs no reset: contents are only readable between the pointers
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/r2r_wave_sequencer.sv
// Rate-controlled code generator for the R2R ladder: divider, config
// registers, stream/saw/triangle/square generator and sticky underrun.
module r2r_wave_sequencer
  import r2r_seq_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = DIV_RESET_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       clr_underrun,
  output logic [7:0] r2r_out,
  output logic       tick,
  output logic       underrun
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_INIT = DIV_WIDTH'(DIV_RESET);

  logic [DIV_WIDTH-1:0] div_r, cnt_r, div_nxt_s;
  logic [15:0]          div16_s;
  logic [7:0]           step_r;
  mode_e                mode_r, pend_mode_r;
  logic                 dir_down_r, dir_cur_s, dir_down_nxt_s;
  logic [8:0]           sum_s;
  logic [7:0]           out_nxt_s;
  logic                 upd_s, pop_s, underrun_set_s;
  logic [7:0]           fifo_rdata_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]     fifo_count_s;

  r2r_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && !fifo_full_s),
    .pop   (pop_s),
    .wdata (s_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign s_ready = (fifo_count_s != CNT_W'(FIFO_DEPTH));

  // Byte writes into div; only the low 16 bits are addressable.
  always_comb begin
    div16_s   = 16'(div_r);
    div_nxt_s = div_r;
    if (cfg_we && (cfg_addr == CFG_DIV_LO)) begin
      div_nxt_s = DIV_WIDTH'({div16_s[15:8], cfg_data});
    end else if (cfg_we && (cfg_addr == CFG_DIV_HI)) begin
      div_nxt_s = DIV_WIDTH'({cfg_data, div16_s[7:0]});
    end else begin
      div_nxt_s = div_r;
    end
  end

  // Next output code; the mode becoming active at this update is pend_mode_r.
  always_comb begin
    upd_s          = ena && (cnt_r == {DIV_WIDTH{1'b0}});
    sum_s          = {1'b0, r2r_out} + {1'b0, step_r};
    dir_cur_s      = (mode_r == MODE_TRI) ? dir_down_r : 1'b0;
    out_nxt_s      = r2r_out;
    dir_down_nxt_s = dir_down_r;
    pop_s          = 1'b0;
    underrun_set_s = 1'b0;
    if (upd_s) begin
      case (pend_mode_r)
        MODE_STREAM: begin
          if (!fifo_empty_s) begin
            out_nxt_s = fifo_rdata_s;
            pop_s     = 1'b1;
          end else begin
            underrun_set_s = 1'b1;
          end
        end
        MODE_SAW: out_nxt_s = sum_s[7:0];
        MODE_TRI: begin
          if (!dir_cur_s) begin
            if (sum_s[8]) begin
              out_nxt_s      = 8'hFF;
              dir_down_nxt_s = 1'b1;
            end else begin
              out_nxt_s      = sum_s[7:0];
              dir_down_nxt_s = 1'b0;
            end
          end else begin
            if (r2r_out < step_r) begin
              out_nxt_s      = 8'h00;
              dir_down_nxt_s = 1'b0;
            end else begin
              out_nxt_s      = r2r_out - step_r;
              dir_down_nxt_s = 1'b1;
            end
          end
        end
        MODE_SQUARE: out_nxt_s = (r2r_out == 8'h00) ? step_r : 8'h00;
        default:     out_nxt_s = r2r_out;
      endcase
    end else begin
      out_nxt_s = r2r_out;
    end
  end

  // Config registers and divider; a new div only matters at the next reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r       <= DIV_INIT;
      cnt_r       <= DIV_INIT;
      step_r      <= STEP_RESET;
      pend_mode_r <= MODE_STREAM;
    end else begin
      div_r <= div_nxt_s;
      if (ena) cnt_r <= upd_s ? div_r : cnt_r - DIV_WIDTH'(1);
      if (cfg_we) begin
        case (cfg_addr)
          CFG_STEP: step_r      <= cfg_data;
          CFG_MODE: pend_mode_r <= mode_e'(cfg_data[1:0]);
          default:  step_r      <= step_r;
        endcase
      end
    end
  end

  // Generator state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r     <= MODE_STREAM;
      dir_down_r <= 1'b0;
      r2r_out    <= 8'h00;
      tick       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (upd_s) mode_r <= pend_mode_r;
      dir_down_r <= dir_down_nxt_s;
      r2r_out    <= out_nxt_s;
      tick       <= upd_s;
      if (underrun_set_s)    underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r2r_wave_sequencer.sv
// Directed bench for r2r_wave_sequencer: divider timing, each waveform,
// stream FIFO back-pressure/underrun, enable freeze and async reset.
module tb_r2r_wave_sequencer;

  logic       clk, rst, ena, cfg_we, s_valid, s_ready, clr_underrun, tick, underrun;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data, s_data, r2r_out;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n;
  int         first;

  r2r_wave_sequencer #(.DIV_WIDTH(16), .DIV_RESET(999), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .clr_underrun(clr_underrun), .r2r_out(r2r_out), .tick(tick), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  // Waits for a tick; returns the number of edges it took.
  task automatic wait_tick(input int budget, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (tick !== 1'b1 && cnt < budget);
    chk("tick_within_budget", {31'd0, tick}, 32'd1);
  endtask

  task automatic first_tick_after_reset(input string tag);
    first = 0;
    for (int k = 1; k <= 1100; k++) begin
      cyc();
      if (tick === 1'b1) begin
        first = k;
        break;
      end
    end
    chk({tag, "_first_tick"}, 32'(first), 32'd1000);
    chk({tag, "_out_after_first"}, {24'd0, r2r_out}, 32'h00);
    chk({tag, "_underrun_after_first"}, {31'd0, underrun}, 32'd1);
  endtask

  logic [7:0] saw_exp [3] = '{8'hC0, 8'h20, 8'h80};
  logic [7:0] tri_exp [8] = '{8'hA0, 8'hF0, 8'hFF, 8'hAF, 8'h5F, 8'h0F, 8'h00, 8'h50};
  logic [7:0] str_exp [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    rst = 1'b1; ena = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00;
    s_valid = 1'b0; s_data = 8'h00; clr_underrun = 1'b0;
    repeat (3) cyc();
    chk("reset_out", {24'd0, r2r_out}, 32'h00);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    chk("reset_underrun", {31'd0, underrun}, 32'd0);
    chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
    rst = 1'b0;

    // default divider, STREAM with empty FIFO
    first_tick_after_reset("init");
    clr_underrun = 1'b1; cyc(); clr_underrun = 1'b0;
    chk("clr_underrun_1", {31'd0, underrun}, 32'd0);

    // SAW, div=3, step=0x60
    cfg_write(2'd0, 8'h03);
    cfg_write(2'd1, 8'h00);
    cfg_write(2'd2, 8'h60);
    cfg_write(2'd3, 8'h01);
    wait_tick(1100, n);
    chk("saw_0", {24'd0, r2r_out}, 32'h60);
    for (int i = 0; i < 3; i++) begin
      wait_tick(10, n);
      chk("saw_period", 32'(n), 32'd4);
      chk("saw_value", {24'd0, r2r_out}, {24'd0, saw_exp[i]});
    end

    // wrap back to 0x00, then TRI with div=0, step=0x50
    cfg_write(2'd2, 8'h80);
    wait_tick(10, n);
    chk("saw_wrap_to_zero", {24'd0, r2r_out}, 32'h00);
    cfg_write(2'd2, 8'h50);
    cfg_write(2'd3, 8'h02);
    cfg_write(2'd0, 8'h00);
    wait_tick(10, n);
    chk("tri_first_latency", 32'(n), 32'd1);
    chk("tri_0", {24'd0, r2r_out}, 32'h50);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("tri_tick_every_cycle", {31'd0, tick}, 32'd1);
      chk("tri_value", {24'd0, r2r_out}, {24'd0, tri_exp[i]});
    end

    // STREAM, div=1: underrun on empty FIFO holds the output
    cfg_write(2'd3, 8'h00);
    cfg_write(2'd0, 8'h01);
    ena = 1'b0;
    chk("stream_empty_underrun", {31'd0, underrun}, 32'd1);
    chk("stream_empty_hold", {24'd0, r2r_out}, 32'hA0);
    clr_underrun = 1'b1; cyc(); clr_underrun = 1'b0;
    chk("clr_underrun_2", {31'd0, underrun}, 32'd0);

    s_valid = 1'b1;
    s_data = 8'h11; cyc();
    s_data = 8'h22; cyc();
    s_data = 8'h33; cyc();
    s_data = 8'h44; cyc();
    chk("fifo_full_not_ready", {31'd0, s_ready}, 32'd0);
    s_data = 8'h55;
    ena = 1'b1;
    cyc();
    chk("stream_tick_0", {31'd0, tick}, 32'd1);
    chk("stream_0", {24'd0, r2r_out}, 32'h11);
    chk("ready_after_pop", {31'd0, s_ready}, 32'd1);
    cyc();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(10, n);
      chk("stream_value", {24'd0, r2r_out}, {24'd0, str_exp[i]});
      chk("stream_no_underrun", {31'd0, underrun}, 32'd0);
    end
    wait_tick(10, n);
    chk("stream_drained_underrun", {31'd0, underrun}, 32'd1);
    chk("stream_drained_hold", {24'd0, r2r_out}, 32'h55);
    ena = 1'b0;
    clr_underrun = 1'b1; cyc(); clr_underrun = 1'b0;
    chk("clr_underrun_3", {31'd0, underrun}, 32'd0);

    // SQUARE, step=0x80, div=5 then div write mid-count
    cfg_write(2'd2, 8'h80);
    cfg_write(2'd3, 8'h03);
    cfg_write(2'd0, 8'h05);
    ena = 1'b1;
    wait_tick(10, n);
    chk("sq_from_nonzero", {24'd0, r2r_out}, 32'h00);
    wait_tick(10, n);
    chk("sq_period_6", 32'(n), 32'd6);
    chk("sq_high", {24'd0, r2r_out}, 32'h80);
    cyc();
    cfg_write(2'd0, 8'h02);
    wait_tick(10, n);
    chk("sq_current_period_kept", 32'(n), 32'd4);
    chk("sq_low", {24'd0, r2r_out}, 32'h00);
    wait_tick(10, n);
    chk("sq_new_period", 32'(n), 32'd3);
    chk("sq_high_2", {24'd0, r2r_out}, 32'h80);

    // ena=0 freeze for 10 cycles mid-count, FIFO filled meanwhile
    cyc();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'hA0 + 8'(i);
      s_valid = (i < 4);
      cyc();
      chk("frozen_no_tick", {31'd0, tick}, 32'd0);
    end
    s_valid = 1'b0;
    chk("fifo_full_outside_stream", {31'd0, s_ready}, 32'd0);
    ena = 1'b1;
    wait_tick(10, n);
    chk("counter_held", 32'(n), 32'd2);
    chk("sq_low_2", {24'd0, r2r_out}, 32'h00);
    wait_tick(10, n);
    chk("sq_high_3", {24'd0, r2r_out}, 32'h80);

    // asynchronous reset mid-period
    cyc();
    rst = 1'b1;
    #1;
    chk("async_rst_out", {24'd0, r2r_out}, 32'h00);
    chk("async_rst_tick", {31'd0, tick}, 32'd0);
    chk("async_rst_underrun", {31'd0, underrun}, 32'd0);
    chk("async_rst_s_ready", {31'd0, s_ready}, 32'd1);
    #1;
    rst = 1'b0;
    first_tick_after_reset("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
